// File: rtl/mips_multicycle_ctrl.sv
// Moore main-control FSM sequencing the shared multicycle MIPS datapath.
// Optional macro BNE_EN adds the BNEEX state (code 12) for opcode 000101.
module mips_multicycle_ctrl #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       pc_en,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
`ifdef BNE_EN
    BNEEX   = 4'd12,
`endif
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t state;
  logic   mem_rdy;
  logic   op_known;
  logic   branch_cond;

  // Zero-wait builds tie the handshake off so every access completes at once.
  assign mem_rdy   = USE_MEM_READY ? mem_ready : 1'b1;
  assign state_out = reset ? 4'd0 : state;

  always_comb begin
    op_known = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_known = 1'b1;
`ifdef BNE_EN
      OP_BNE: op_known = 1'b1;
`endif
      default: op_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   if (mem_rdy) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= RTYPEEX;
            OP_BEQ:       state <= BEQEX;
            OP_ADDI:      state <= ADDIEX;
            OP_J:         state <= JEX;
`ifdef BNE_EN
            OP_BNE:       state <= BNEEX;
`endif
            default:      state <= FETCH;
          endcase
        end
        MEMADR:  state <= (opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   if (mem_rdy) state <= MEMWB;
        MEMWR:   if (mem_rdy) state <= FETCH;
        RTYPEEX: state <= RTYPEWB;
        ADDIEX:  state <= ADDIWB;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    branch_cond = 1'b0;
    pcsrc       = 2'b00;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    reg_write   = 1'b0;
    illegal_op  = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        alusrcb  = 2'b01;
        ir_write = mem_rdy;
        pc_write = mem_rdy;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        illegal_op = ~op_known;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      MEMWB: begin
        memtoreg  = 1'b1;
        reg_write = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst    = 1'b1;
        reg_write = 1'b1;
      end
      BEQEX: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcsrc       = 2'b01;
        branch      = 1'b1;
        branch_cond = zero;
      end
`ifdef BNE_EN
      BNEEX: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcsrc       = 2'b01;
        branch      = 1'b1;
        branch_cond = ~zero;
      end
`endif
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: reg_write = 1'b1;
      JEX: begin
        pcsrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    // Reset presents the FETCH datapath selects with every enable squashed.
    if (reset) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      pcsrc      = 2'b00;
      alusrca    = 1'b0;
      alusrcb    = 2'b01;
      aluop      = 2'b00;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
    pc_en = pc_write | (branch & branch_cond);
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed scenarios plus
// randomized instruction streams checked against an instruction-level model.
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write, branch, pc_en;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic       alusrca, regdst, memtoreg, reg_write, illegal_op;
  logic [3:0] state_out;

  int checks = 0;
  int errors = 0;

  // Packed observation bit positions.
  localparam int B_ILL = 0, B_RW = 1, B_RD = 3, B_PCEN = 11, B_PCW = 13;
  localparam int B_IORD = 15, B_MWR = 16, B_MRD = 17;

  logic [3:0]  exp_st[$];
  logic [3:0]  obs_st[$];
  logic [17:0] exp_o[$];
  logic [17:0] obs_o[$];

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .pc_en(pc_en), .pcsrc(pcsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .regdst(regdst),
    .memtoreg(memtoreg), .reg_write(reg_write), .illegal_op(illegal_op),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [5:0] op);
    bit ok;
    ok = (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) || (op == 6'h04) ||
         (op == 6'h08) || (op == 6'h02);
`ifdef BNE_EN
    ok = ok || (op == 6'h05);
`endif
    return ok;
  endfunction

  // Expected output vector for one cycle, straight from the per-state table.
  function automatic logic [17:0] model_out(input int st, input logic mr,
                                            input logic z, input logic [5:0] op);
    logic mrd, mwr, io, irw, pcw, br, bc, pcen, asa, rd, m2r, rw, ill;
    logic [1:0] pcs, asb, aop;
    {mrd, mwr, io, irw, pcw, br, bc, asa, rd, m2r, rw, ill} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  begin asb = 2'b11; ill = !is_legal(op); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin io = 1; mrd = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mwr = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; bc = z; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcw = 1; end
`ifdef BNE_EN
      12: begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; bc = !z; end
`endif
      default: ;
    endcase
    pcen = pcw | (br & bc);
    return {mrd, mwr, io, irw, pcw, br, pcen, pcs, asa, asb, aop, rd, m2r, rw, ill};
  endfunction

  // Runs one instruction from FETCH; fw/mw are fetch and data-memory wait
  // cycles, zmode 0/1 fixes zero, 2 randomizes it every cycle.
  // Entered and left at posedge+1 with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input int zmode);
    logic mrq[$];
    exp_st.delete(); obs_st.delete(); exp_o.delete(); obs_o.delete();
    for (int i = 0; i < fw; i++) begin exp_st.push_back(0); mrq.push_back(0); end
    exp_st.push_back(0); mrq.push_back(1);
    exp_st.push_back(1); mrq.push_back(1'($urandom));
    case (op)
      6'h23: begin
        exp_st.push_back(2); mrq.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin exp_st.push_back(3); mrq.push_back(0); end
        exp_st.push_back(3); mrq.push_back(1);
        exp_st.push_back(4); mrq.push_back(1'($urandom));
      end
      6'h2B: begin
        exp_st.push_back(2); mrq.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin exp_st.push_back(5); mrq.push_back(0); end
        exp_st.push_back(5); mrq.push_back(1);
      end
      6'h00: begin
        exp_st.push_back(6); mrq.push_back(1'($urandom));
        exp_st.push_back(7); mrq.push_back(1'($urandom));
      end
      6'h04: begin exp_st.push_back(8); mrq.push_back(1'($urandom)); end
      6'h08: begin
        exp_st.push_back(9); mrq.push_back(1'($urandom));
        exp_st.push_back(10); mrq.push_back(1'($urandom));
      end
      6'h02: begin exp_st.push_back(11); mrq.push_back(1'($urandom)); end
`ifdef BNE_EN
      6'h05: begin exp_st.push_back(12); mrq.push_back(1'($urandom)); end
`endif
      default: ;
    endcase
    opcode = op;
    for (int i = 0; i < exp_st.size(); i++) begin
      mem_ready = mrq[i];
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      @(negedge clk);
      obs_st.push_back(state_out);
      obs_o.push_back({mem_read, mem_write, iord, ir_write, pc_write, branch, pc_en,
                       pcsrc, alusrca, alusrcb, aluop, regdst, memtoreg, reg_write,
                       illegal_op});
      exp_o.push_back(model_out(int'(exp_st[i]), mrq[i], zero, op));
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'h3F;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (state_out !== 4'd0) begin
        errors++; $display("FAIL reset_state got %0d want 0", state_out);
      end
      checks++;
      if ({mem_read, mem_write, ir_write, pc_write, reg_write, pc_en, illegal_op} !== 7'b0) begin
        errors++;
        $display("FAIL reset_enables got %b want 0000000",
                 {mem_read, mem_write, ir_write, pc_write, reg_write, pc_en, illegal_op});
      end
      checks++;
      if ({alusrcb, aluop, iord, alusrca} !== 6'b010000) begin
        errors++; $display("FAIL reset_selects got %b want 010000",
                           {alusrcb, aluop, iord, alusrca});
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({state_out, mem_read, ir_write, pc_write, pc_en} !== 8'b0000_1111) begin
      errors++;
      $display("FAIL first_fetch got st=%0d mr=%b irw=%b pcw=%b pcen=%b want 0 1 1 1 1",
               state_out, mem_read, ir_write, pc_write, pc_en);
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw_wait();
    int want[8] = '{0, 1, 2, 3, 3, 3, 3, 4};
    run_instr(6'h23, 0, 3, 2);
    checks++;
    if (obs_st.size() != 8) begin
      errors++; $display("FAIL lw_len got %0d want 8", obs_st.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_st[i] !== 4'(want[i])) begin
          errors++; $display("FAIL lw_state[%0d] got %0d want %0d", i, obs_st[i], want[i]);
        end
        checks++;
        if (obs_o[i][B_IORD] !== (want[i] == 3) || obs_o[i][B_RW] !== (want[i] == 4)) begin
          errors++; $display("FAIL lw_iord_rw[%0d] got %b%b want %b%b", i,
                             obs_o[i][B_IORD], obs_o[i][B_RW], want[i] == 3, want[i] == 4);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (state_out !== 4'd0) begin
      errors++; $display("FAIL lw_return got %0d want 0", state_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      run_instr(6'h04, 0, 0, z);
      checks++;
      if (obs_st.size() != 3 || obs_st[2] !== 4'd8) begin
        errors++; $display("FAIL beq_state z=%0d got %0d want 8", z, obs_st[obs_st.size()-1]);
      end
      checks++;
      if ({obs_o[2][5:4], obs_o[2][10:9], obs_o[2][B_PCEN], obs_o[2][B_PCW]} !==
          {2'b01, 2'b01, 1'(z), 1'b0}) begin
        errors++; $display("FAIL beq_out z=%0d got aluop=%b pcsrc=%b pcen=%b pcw=%b want 01 01 %0d 0",
                           z, obs_o[2][5:4], obs_o[2][10:9], obs_o[2][B_PCEN], obs_o[2][B_PCW], z);
      end
    end
  endtask

  task automatic test_rtype();
    int want[4] = '{0, 1, 6, 7};
    run_instr(6'h00, 0, 0, 2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_st[i] !== 4'(want[i])) begin
        errors++; $display("FAIL rtype_state[%0d] got %0d want %0d", i, obs_st[i], want[i]);
      end
    end
    checks++;
    if (obs_o[2][5:4] !== 2'b10) begin
      errors++; $display("FAIL rtype_aluop got %b want 10", obs_o[2][5:4]);
    end
    checks++;
    if ({obs_o[3][B_RD], obs_o[3][B_RW]} !== 2'b11) begin
      errors++; $display("FAIL rtype_wb got %b want 11", {obs_o[3][B_RD], obs_o[3][B_RW]});
    end
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 1, 0, 2);
    for (int i = 0; i < obs_st.size(); i++) begin
      checks++;
      if (obs_st[i] !== exp_st[i] || obs_o[i][B_ILL] !== (exp_st[i] == 1) ||
          obs_o[i][B_RW] !== 1'b0 || obs_o[i][B_MWR] !== 1'b0) begin
        errors++; $display("FAIL illegal[%0d] got st=%0d ill=%b rw=%b mw=%b want st=%0d ill=%b 0 0",
                           i, obs_st[i], obs_o[i][B_ILL], obs_o[i][B_RW], obs_o[i][B_MWR],
                           exp_st[i], exp_st[i] == 1);
      end
    end
    @(negedge clk);
    checks++;
    if (state_out !== 4'd0 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL illegal_return got st=%0d ill=%b want 0 0", state_out, illegal_op);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    opcode = 6'h2B; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_out !== 4'd5 || mem_write !== 1'b1) begin
      errors++; $display("FAIL abort_memwr got st=%0d mw=%b want 5 1", state_out, mem_write);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b0 || state_out !== 4'd0) begin
      errors++; $display("FAIL abort_same_cycle got mw=%b st=%0d want 0 0", mem_write, state_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (state_out !== 4'd0 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
      errors++; $display("FAIL abort_after got st=%0d mr=%b mw=%b want 0 1 0",
                         state_out, mem_read, mem_write);
    end
    @(posedge clk); #1;
  endtask

`ifdef BNE_EN
  task automatic test_bne();
    run_instr(6'h05, 0, 0, 0);
    checks++;
    if (obs_st[2] !== 4'd12 || obs_o[2][B_PCEN] !== 1'b1) begin
      errors++; $display("FAIL bne got st=%0d pcen=%b want 12 1", obs_st[2], obs_o[2][B_PCEN]);
    end
  endtask
`endif

  task automatic test_random(input int n, input int maxwait);
    logic [5:0] ops[7] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h05};
    logic [5:0] op;
    for (int k = 0; k < n; k++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      run_instr(op, $urandom_range(0, maxwait), $urandom_range(0, maxwait), 2);
      for (int i = 0; i < exp_st.size(); i++) begin
        checks++;
        if (obs_st[i] !== exp_st[i] || obs_o[i] !== exp_o[i]) begin
          errors++;
          $display("FAIL rand k=%0d op=%h cyc=%0d got st=%0d out=%h want st=%0d out=%h",
                   k, op, i, obs_st[i], obs_o[i], exp_st[i], exp_o[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_beq();
    test_rtype();
    test_illegal();
    test_reset_abort();
`ifdef BNE_EN
    test_bne();
`endif
    test_random(40, 2);
    test_random(20, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style main control FSM that sequences the shared MIPS datapath over multiple cycles.
- Shared datapath: one ALU, a unified instruction/data memory port, register file, PC and IR.
- Emits the 2-bit ALUOp consumed by the existing ALU_control decoder, plus all mux selects and write enables.
- Memory accesses stall on a ready handshake.

Parameters:
- USE_MEM_READY, 1: 1 = honour mem_ready; 0 = mem_ready treated as constant 1 (zero-wait memory).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; stable from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  IR load enable
- pc_write  out  1  unconditional PC write
- branch  out  1  conditional-branch qualifier
- pc_en  out  1  pc_write | (branch & branch_cond)
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alusrca  out  1  0 = PC, 1 = A register
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- aluop  out  2  to ALU_control: 00 add, 01 sub, 10 funct-decoded
- regdst  out  1  0 = rt, 1 = rd
- memtoreg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write
- illegal_op  out  1  single-cycle pulse on unrecognised opcode
- state_out  out  4  current state code (debug/verification)

Behaviour:
- Reset:
  - reset is sampled at the clk edge; the next state is FETCH.
  - While reset is high, mem_read, mem_write, ir_write, pc_write, reg_write, pc_en and illegal_op are forced to 0. All other outputs take their FETCH values.
  - Reset asserted mid-operation aborts immediately, including a pending memory wait.
- Outputs decode from the state register only, except:
  - ir_write and pc_write in FETCH, which are gated by mem_ready.
  - pc_en, which is combinational on zero.
- Any output not listed for a state is 0.
- State codes and behaviour:
  - FETCH=0:
    - Outputs: mem_read=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, ir_write=pc_write=mem_ready.
    - Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE=1:
    - Outputs: alusrca=0, alusrcb=11, aluop=00 (precompute branch target).
    - Next state by opcode: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX.
    - Any other opcode -> FETCH with illegal_op=1 for this cycle.
  - MEMADR=2:
    - Outputs: alusrca=1, alusrcb=10, aluop=00.
    - Next: MEMRD if opcode=100011, else MEMWR.
  - MEMRD=3:
    - Outputs: iord=1, mem_read=1.
    - Hold until mem_ready=1, then go to MEMWB.
  - MEMWB=4: regdst=0, memtoreg=1, reg_write=1; next FETCH.
  - MEMWR=5:
    - Outputs: iord=1, mem_write=1, held continuously while waiting.
    - Go to FETCH on mem_ready=1.
  - RTYPEEX=6: alusrca=1, alusrcb=00, aluop=10; next RTYPEWB.
  - RTYPEWB=7: regdst=1, memtoreg=0, reg_write=1; next FETCH.
  - BEQEX=8:
    - Outputs: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, branch_cond=zero.
    - Next FETCH.
  - ADDIEX=9: alusrca=1, alusrcb=10, aluop=00; next ADDIWB.
  - ADDIWB=10: regdst=0, memtoreg=0, reg_write=1; next FETCH.
  - JEX=11: pcsrc=10, pc_write=1; next FETCH.
- Codes 12–15 (unused): all enables 0; next state FETCH.
- Latencies at zero wait:

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw | 4 |
  | R-type | 4 |
  | addi | 4 |
  | beq | 3 |
  | j | 3 |
  | illegal | 2 |

  Each memory wait cycle adds 1.
- aluop=11 is never driven.

Optional Feature:
- Macro BNE_EN.
- Defined:
  - Opcode 000101 in DECODE -> BNEEX=12.
  - BNEEX outputs are identical to BEQEX except branch_cond = ~zero. Next FETCH.
- Undefined:
  - Opcode 000101 is illegal: DECODE -> FETCH with illegal_op pulse.
  - Code 12 is treated as unused.

Test Plan:
- reset high 2 cycles, then low, mem_ready=1 -> state_out=0 and all enables 0 during reset. First post-reset cycle: mem_read=1, ir_write=1, pc_write=1, pc_en=1.
- opcode=100011, mem_ready low for 3 cycles in MEMRD -> state_out sequence 0,1,2,3,3,3,3,4,0. iord=1 throughout MEMRD. reg_write=1 only in state 4.
- opcode=000100 with zero=1 -> BEQEX gives aluop=01, pcsrc=01, pc_en=1. Repeat with zero=0 -> pc_en=0 and pc_write=0.
- opcode=000000 -> states 0,1,6,7,0. aluop=10 in state 6. regdst=1 and reg_write=1 in state 7.
- opcode=111111 -> states 0,1,0; illegal_op=1 for exactly the DECODE cycle; no reg_write or mem_write.
- reset asserted while in MEMWR with mem_ready=0 -> mem_write=0 the same cycle and state_out=0 next cycle. With BNE_EN, opcode=000101 and zero=0 -> state 12 with pc_en=1.
